// File: rtl/log_pkg.sv
// Shared constants and FSM state type for the log range-reduce stage and the evaluator.
package log_pkg;
    localparam int DIN_W  = 32;
    localparam int MANT_W = 32;
    localparam int FRAC_W = 30;
    localparam int EXP_W  = 6;

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
endpackage

// File: rtl/log_range_reduce_if.sv
// Operand-in / result-out handshake bundle for log_range_reduce.
interface log_range_reduce_if;
    import log_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [DIN_W-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_zero;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_mant, out_exp, out_zero);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_mant, out_exp, out_zero);
endinterface

// File: rtl/log_range_reduce.sv
// Iterative normaliser: shifts the operand left until bit31 is set, emits Q2.30 mantissa,
// MSB exponent and zero flag. Optional LOG_RR_COARSE_SHIFT_EN adds 8-bit skip steps.
module log_range_reduce
    import log_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    log_range_reduce_if.slave bus
);
    state_t             r_state;
    logic [DIN_W-1:0]   r_sr;
    logic [4:0]         r_cnt;
    logic               r_in_ready;
    logic               r_valid;
    logic [MANT_W-1:0]  r_mant;
    logic [EXP_W-1:0]   r_exp;
    logic               r_zero;
    logic [4:0]         w_msb;

    assign w_msb = 5'd31 - r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sr       <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            r_valid    <= 1'b0;
            r_mant     <= '0;
            r_exp      <= '0;
            r_zero     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_sr       <= bus.in_data;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        if (bus.in_data == '0) begin
                            r_mant  <= '0;
                            r_exp   <= '0;
                            r_zero  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (r_sr[31]) begin
                        r_mant  <= {1'b0, r_sr[31:1]};
                        r_exp   <= {{(EXP_W-5){1'b0}}, w_msb};
                        r_zero  <= 1'b0;
                        r_state <= DONE;
                    end else
`ifdef LOG_RR_COARSE_SHIFT_EN
                    // Top byte empty: skip eight positions at once; cnt stays <= 31 since sr != 0.
                    if (r_sr[31:24] == 8'd0) begin
                        r_sr  <= {r_sr[23:0], 8'd0};
                        r_cnt <= r_cnt + 5'd8;
                    end else
`endif
                    begin
                        r_sr  <= {r_sr[30:0], 1'b0};
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                DONE: begin
                    // out_valid rises one cycle after entering DONE, then waits for out_ready.
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_valid    <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_mant  = r_mant;
    assign bus.out_exp   = r_exp;
    assign bus.out_zero  = r_zero;
endmodule

// File: tb/tb_log_range_reduce.sv
// Directed plus random operands against a bit-search reference model of log2 range reduction.
module tb_log_range_reduce;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    log_range_reduce_if bus();
    log_range_reduce dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: find MSB by scanning, mantissa = operand moved so MSB lands at bit30.
    task automatic model(input logic [31:0] x, output logic [31:0] mant, output int e,
                         output logic z, output int lat);
        int msb, s;
        logic [63:0] wide;
        msb = -1;
        for (int i = 0; i < 32; i++) if (x[i]) msb = i;
        if (msb < 0) begin
            mant = 32'd0; e = 0; z = 1'b1; lat = 1;
        end else begin
            s    = 31 - msb;
            wide = 64'(x) << s;
            mant = wide[32:1];
            e    = msb;
            z    = 1'b0;
`ifdef LOG_RR_COARSE_SHIFT_EN
            lat  = 2 + s / 8 + s % 8;
`else
            lat  = 2 + s;
`endif
        end
    endtask

    // Called ~1 time unit after a rising edge; returns in the same phase.
    task automatic run_op(input logic [31:0] x, input int hold, input string tag);
        logic [31:0] em;
        logic        ez;
        int          ee, elat, lat;
        logic [31:0] m0;
        logic [5:0]  e0;
        model(x, em, ee, ez, elat);
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(elat));
        check({tag, ".mant"}, 64'(bus.out_mant), 64'(em));
        check({tag, ".exp"},  64'(bus.out_exp),  64'(ee));
        check({tag, ".zero"}, 64'(bus.out_zero), 64'(ez));
        m0 = bus.out_mant;
        e0 = bus.out_exp;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_vld"},  64'(bus.out_valid), 64'd1);
            check({tag, ".hold_rdy"},  64'(bus.in_ready),  64'd0);
            check({tag, ".hold_mant"}, 64'(bus.out_mant),  64'(m0));
            check({tag, ".hold_exp"},  64'(bus.out_exp),   64'(e0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, ".drop_vld"}, 64'(bus.out_valid), 64'd0);
        check({tag, ".back_rdy"}, 64'(bus.in_ready),  64'd1);
    endtask

    initial begin
        logic [31:0] x;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check("rst.in_ready",  64'(bus.in_ready),  64'd1);
        check("rst.mant",      64'(bus.out_mant),  64'd0);
        check("rst.exp",       64'(bus.out_exp),   64'd0);
        check("rst.zero",      64'(bus.out_zero),  64'd0);
        rst = 1'b0;

        run_op(32'h8000_0000, 0, "msb31");
        run_op(32'h0000_0001, 0, "msb0");
        run_op(32'h0000_0006, 0, "six");
        run_op(32'h0000_0000, 0, "zero");
        run_op(32'hFFFF_FFFF, 0, "ones");
        run_op(32'h0080_0000, 0, "msb23");
        run_op(32'h0000_0100, 5, "bp");

        // Reset in the middle of a long normalisation
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0000_0001;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst.out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst.in_ready",  64'(bus.in_ready),  64'd1);
        check("mid_rst.mant",      64'(bus.out_mant),  64'd0);
        check("mid_rst.exp",       64'(bus.out_exp),   64'd0);
        check("mid_rst.zero",      64'(bus.out_zero),  64'd0);
        run_op(32'h0000_0003, 0, "after_rst");

        for (int n = 0; n < 24; n++) begin
            x = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) x = 32'd0;
            run_op(x, $urandom_range(0, 3), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/log_range_reduce.md
Name: log_range_reduce

Overview:
- Upstream operand-conditioning stage for the piecewise-linear log evaluator.
- Takes an unsigned integer operand and normalises it iteratively: one left shift per cycle until the MSB is set.
- Emits a Q2.30 mantissa in [1,2), plus the integer exponent and a zero flag.
- The mantissa drives the evaluator's signed 32-bit x input; the exponent is added downstream as the integer part of log2.

Parameters:
- DIN_W, 32, operand width (unsigned); fixed at 32 in this revision.
- EXP_W, 6, exponent output width (holds 0..31).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  DIN_W  unsigned operand.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_mant  output  32  Q2.30 mantissa: bit31=0, bit30=1 unless zero.
- out_exp  output  EXP_W  MSB index of the operand, 0..31.
- out_zero  output  1  operand was 0.

Behaviour:
- Interface decision: one clock, clk; rst is synchronous and active-high.
- Reset, at the next clk edge with rst high:
  - state=IDLE; shift register sr=0; shift count cnt=0.
  - out_valid=0, out_mant=0, out_exp=0, out_zero=0, in_ready=1.
  - An operand in flight is discarded; rst has priority over all other events.
- FSM states: IDLE, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready (cycle T): sr<=in_data, cnt<=0.
  - in_data==0: go to DONE with zero=1.
  - Otherwise: go to NORM.
- NORM:
  - in_ready=0.
  - If sr[31]==0: sr<=sr<<1, cnt<=cnt+1.
  - If sr[31]==1: latch the result and go to DONE.
- Result computation:
  - out_mant={1'b0, sr[31:1]}; the operand LSB is truncated when msb=31.
  - out_exp=31-cnt.
  - out_zero=0.
- Zero operand: out_mant=0, out_exp=0, out_zero=1.
- DONE:
  - out_valid=1, in_ready=0.
  - Outputs are held stable while out_ready=0.
  - On out_ready=1: go to IDLE and drop out_valid the next cycle.
  - No same-cycle acceptance of a new operand, so one result is in flight at most.
- Latency (accept edge to out_valid):
  - Define s=31-msb.
  - Nonzero operand: 2+s cycles (2 minimum, 33 maximum).
  - Zero operand: 1 cycle.
- cnt is 5 bits and never exceeds 31; no wrap is possible.
- in_data is ignored outside IDLE.

Optional Feature:
- Macro: LOG_RR_COARSE_SHIFT_EN.
- Defined: in NORM, if sr[31:24]==0, then sr<=sr<<8 and cnt<=cnt+8 in one cycle; otherwise a single-bit step as above.
  - Latency becomes 2+floor(s/8)+(s mod 8).
  - Results are bit-identical to the non-coarse build.
- Undefined: single-bit stepping only; no coarse-shift logic is built.

Decomposition:
- Shared package log_pkg holds:
  - state enum {IDLE, NORM, DONE};
  - MANT_W=32 and FRAC_W=30 (Q2.30 constants);
  - EXP_W.
- The evaluator consumes these same constants.
- No sub-module: FSM and shifter together are small enough for one module.

Test Plan:
- in_data=0x8000_0000 accepted at T: out_valid at T+2, out_mant=0x4000_0000, out_exp=31, out_zero=0.
- in_data=0x0000_0001: out_valid at T+33 (T+12 with LOG_RR_COARSE_SHIFT_EN), out_mant=0x4000_0000, out_exp=0.
- in_data=0x0000_0006: out_valid at T+31, out_mant=0x6000_0000, out_exp=2.
- in_data=0: out_valid at T+1, out_zero=1, out_mant=0, out_exp=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Outputs stay constant and in_ready=0 throughout.
  - out_ready=1 → IDLE next cycle.
  - A new operand 0x0000_0100 gives out_exp=8.
- Reset mid-op: rst=1 for 1 cycle during NORM.
  - Next cycle: out_valid=0, in_ready=1, all outputs 0.
  - The subsequent operand 0x0000_0003 gives out_mant=0x6000_0000, out_exp=1.
